// File: rtl/crc32_rx_check.sv
// CRC-32 receive checker: strips the 4-byte FCS, validates CRC and length, reports per-frame status.
// Optional frame statistics are enabled by defining CRC32_RX_CHECK_STATS_EN.
module crc32_rx_check #(
    parameter logic [31:0] CRC_INITIAL_VALUE = 32'hFFFFFFFF,
    parameter logic [31:0] CRC_REMAINDER     = 32'hC704DD7B,
    parameter int          MIN_LEN           = 64,
    parameter int          MAX_LEN           = 1518
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic        in_eof,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_sof,
    output logic        out_eof,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        crc_err,
    output logic        len_err,
    output logic        abort_err,
    output logic [15:0] byte_count,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FILL = 2'd1, ST_STREAM = 2'd2} state_t;

    localparam logic [15:0] MIN_LEN_C = 16'(MIN_LEN);
    localparam logic [15:0] MAX_LEN_C = 16'(MAX_LEN);

    function automatic logic [31:0] parallel_crc(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {data, 24'h000000};
        for (int i = 0; i < 8; i++) begin
            c = c[31] ? ({c[30:0], 1'b0} ^ 32'h04C11DB7) : {c[30:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic len_bad(input logic [15:0] cnt);
        return (cnt < MIN_LEN_C) || (cnt > MAX_LEN_C) || (cnt == 16'hFFFF);
    endfunction

    state_t           state_q, state_d;
    logic [31:0]      crc_q, crc_d;
    logic [3:0][7:0]  dly_q, dly_d;
    logic [1:0]       held_q, held_d;
    logic             first_q, first_d;
    logic [15:0]      byte_count_q, byte_count_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_sof_q, out_sof_d;
    logic             out_eof_q, out_eof_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_ok_q, frame_ok_d;
    logic             crc_err_q, crc_err_d;
    logic             len_err_q, len_err_d;
    logic             abort_err_q, abort_err_d;

    logic [31:0]      crc_start_s, crc_upd_s;
    logic [15:0]      cnt_inc_s;

    assign crc_start_s = parallel_crc(CRC_INITIAL_VALUE, in_data);
    assign crc_upd_s   = parallel_crc(crc_q, in_data);
    assign cnt_inc_s   = (byte_count_q == 16'hFFFF) ? 16'hFFFF : byte_count_q + 16'd1;

    // Next-state, delay line, CRC and status decode
    always_comb begin
        state_d      = state_q;
        crc_d        = crc_q;
        dly_d        = dly_q;
        held_d       = held_q;
        first_d      = first_q;
        byte_count_d = byte_count_q;
        out_valid_d  = 1'b0;
        out_data_d   = 8'h00;
        out_sof_d    = 1'b0;
        out_eof_d    = 1'b0;
        frame_done_d = 1'b0;
        frame_ok_d   = 1'b0;
        crc_err_d    = 1'b0;
        len_err_d    = 1'b0;
        abort_err_d  = 1'b0;
        if (in_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_sof) begin
                        byte_count_d = 16'd1;
                        if (in_eof) begin
                            frame_done_d = 1'b1;
                            crc_err_d    = (crc_start_s != CRC_REMAINDER);
                            len_err_d    = 1'b1;
                            crc_d        = CRC_INITIAL_VALUE;
                        end else begin
                            state_d = ST_FILL;
                            crc_d   = crc_start_s;
                            dly_d   = {24'h000000, in_data};
                            held_d  = 2'd1;
                            first_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FILL, ST_STREAM: begin
                    if (in_sof) begin
                        // A new frame start aborts the open one and restarts on this byte
                        frame_done_d = 1'b1;
                        abort_err_d  = 1'b1;
                        state_d      = ST_FILL;
                        crc_d        = crc_start_s;
                        dly_d        = {24'h000000, in_data};
                        held_d       = 2'd1;
                        first_d      = 1'b1;
                        byte_count_d = 16'd1;
                    end else begin
                        byte_count_d = cnt_inc_s;
                        crc_d        = crc_upd_s;
                        dly_d        = {dly_q[2:0], in_data};
                        if (state_q == ST_STREAM) begin
                            out_valid_d = 1'b1;
                            out_data_d  = dly_q[3];
                            out_sof_d   = first_q;
                            first_d     = 1'b0;
                        end else begin
                            held_d = held_q + 2'd1;
                        end
                        if (in_eof) begin
                            frame_done_d = 1'b1;
                            crc_err_d    = (crc_upd_s != CRC_REMAINDER);
                            len_err_d    = (state_q == ST_FILL) || len_bad(cnt_inc_s);
                            frame_ok_d   = (crc_upd_s == CRC_REMAINDER) &&
                                           (state_q == ST_STREAM) && !len_bad(cnt_inc_s);
                            out_eof_d    = (state_q == ST_STREAM);
                            state_d      = ST_IDLE;
                            crc_d        = CRC_INITIAL_VALUE;
                        end else if ((state_q == ST_FILL) && (held_q == 2'd3)) begin
                            state_d = ST_STREAM;
                        end else begin
                            state_d = state_q;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            crc_q        <= CRC_INITIAL_VALUE;
            dly_q        <= 32'h00000000;
            held_q       <= 2'd0;
            first_q      <= 1'b0;
            byte_count_q <= 16'h0000;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            out_sof_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            crc_err_q    <= 1'b0;
            len_err_q    <= 1'b0;
            abort_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            crc_q        <= crc_d;
            dly_q        <= dly_d;
            held_q       <= held_d;
            first_q      <= first_d;
            byte_count_q <= byte_count_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sof_q    <= out_sof_d;
            out_eof_q    <= out_eof_d;
            frame_done_q <= frame_done_d;
            frame_ok_q   <= frame_ok_d;
            crc_err_q    <= crc_err_d;
            len_err_q    <= len_err_d;
            abort_err_q  <= abort_err_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_sof    = out_sof_q;
    assign out_eof    = out_eof_q;
    assign frame_done = frame_done_q;
    assign frame_ok   = frame_ok_q;
    assign crc_err    = crc_err_q;
    assign len_err    = len_err_q;
    assign abort_err  = abort_err_q;
    assign byte_count = byte_count_q;

`ifdef CRC32_RX_CHECK_STATS_EN
    logic [15:0] good_cnt_q, good_cnt_d;
    logic [15:0] bad_cnt_q, bad_cnt_d;

    // Statistics update alongside the status strobe, wrapping naturally
    always_comb begin
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        if (frame_done_d && frame_ok_d) begin
            good_cnt_d = good_cnt_q + 16'd1;
        end else if (frame_done_d) begin
            bad_cnt_d = bad_cnt_q + 16'd1;
        end else begin
            good_cnt_d = good_cnt_q;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            good_cnt_q <= 16'h0000;
            bad_cnt_q  <= 16'h0000;
        end else begin
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
        end
    end

    assign good_cnt = good_cnt_q;
    assign bad_cnt  = bad_cnt_q;
`else
    assign good_cnt = 16'h0000;
    assign bad_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_crc32_rx_check.sv
// Scoreboard bench for crc32_rx_check: a frame-level model queues expected payload and status,
// a monitor compares whatever the DUT presents.
module tb_crc32_rx_check;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        bit          ok;
        bit          ce;
        bit          le;
        bit          ae;
        logic [15:0] cnt;
    } st_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_sof, in_eof;
    logic [7:0]  in_data;
    logic        out_valid, out_sof, out_eof;
    logic [7:0]  out_data;
    logic        frame_done, frame_ok, crc_err, len_err, abort_err;
    logic [15:0] byte_count, good_cnt, bad_cnt;

    int errors = 0;
    int checks = 0;
    int good_m = 0;
    int bad_m  = 0;
    logic [9:0] exp_b[$];
    st_t        exp_s[$];

    always #5 clk = ~clk;

    crc32_rx_check dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
        .frame_done(frame_done), .frame_ok(frame_ok), .crc_err(crc_err),
        .len_err(len_err), .abort_err(abort_err), .byte_count(byte_count),
        .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Bit-serial CRC over a whole byte list, MSB first, no final inversion
    function automatic logic [31:0] ref_crc(input bq_t b);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            for (int k = 7; k >= 0; k--) begin
                fb = c[31] ^ b[i][k];
                c  = c << 1;
                if (fb) c = c ^ 32'h04C11DB7;
            end
        end
        return c;
    endfunction

    function automatic bq_t build_good(input int plen, input bit zeros);
        bq_t         f;
        logic [31:0] c;
        for (int i = 0; i < plen; i++) f.push_back(zeros ? 8'h00 : 8'($urandom_range(255, 0)));
        c = ~ref_crc(f);
        f.push_back(c[31:24]);
        f.push_back(c[23:16]);
        f.push_back(c[15:8]);
        f.push_back(c[7:0]);
        return f;
    endfunction

    // Queue what the first nsend bytes of frame f should produce
    task automatic expect_frame(input bq_t f, input int nsend);
        int  n;
        bit  complete;
        st_t s;
        n        = f.size();
        complete = (nsend == n);
        for (int i = 0; i <= nsend - 5; i++)
            exp_b.push_back({(complete && i == n - 5) ? 1'b1 : 1'b0, (i == 0) ? 1'b1 : 1'b0, f[i]});
        if (complete) begin
            s.ce  = (ref_crc(f) != 32'hC704DD7B);
            s.le  = (n <= 4) || (n < 64) || (n > 1518);
            s.ok  = !s.ce && !s.le;
            s.ae  = 1'b0;
            s.cnt = 16'(n);
            exp_s.push_back(s);
        end
    endtask

    task automatic expect_abort();
        st_t s;
        s.ok = 1'b0; s.ce = 1'b0; s.le = 1'b0; s.ae = 1'b1; s.cnt = 16'd1;
        exp_s.push_back(s);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        end
    endtask

    // gap_mode: 0 none, 1 every other cycle, 2 random
    task automatic drive(input bq_t f, input int nsend, input int gap_mode);
        for (int i = 0; i < nsend; i++) begin
            if (gap_mode == 1 && i > 0) idle(1);
            if (gap_mode == 2) idle($urandom_range(2, 0));
            @(negedge clk);
            in_valid = 1'b1;
            in_sof   = (i == 0);
            in_eof   = (i == f.size() - 1);
            in_data  = f[i];
        end
    endtask

    task automatic send(input bq_t f, input int gap_mode);
        expect_frame(f, f.size());
        drive(f, f.size(), gap_mode);
        idle(1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_sof_eof"}, {out_sof, out_eof}, 0);
        check({tag, "_status"}, {frame_done, frame_ok, crc_err, len_err, abort_err}, 0);
        check({tag, "_byte_count"}, byte_count, 0);
        check({tag, "_good_cnt"}, good_cnt, 0);
        check({tag, "_bad_cnt"}, bad_cnt, 0);
    endtask

    // Monitor: compare every presented output against the queued expectations
    initial begin
        logic [9:0] e;
        st_t        s;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && out_valid) begin
                if (exp_b.size() == 0) check("unexpected_out_valid", 1, 0);
                else begin
                    e = exp_b.pop_front();
                    check("out_data", out_data, e[7:0]);
                    check("out_sof", out_sof, e[8]);
                    check("out_eof", out_eof, e[9]);
                end
            end
            if (!reset && frame_done) begin
                if (exp_s.size() == 0) check("unexpected_frame_done", 1, 0);
                else begin
                    s = exp_s.pop_front();
                    check("frame_ok", frame_ok, s.ok);
                    check("crc_err", crc_err, s.ce);
                    check("len_err", len_err, s.le);
                    check("abort_err", abort_err, s.ae);
                    check("byte_count", byte_count, s.cnt);
                    if (s.ok) good_m++; else bad_m++;
`ifdef CRC32_RX_CHECK_STATS_EN
                    check("good_cnt", good_cnt, good_m);
                    check("bad_cnt", bad_cnt, bad_m);
`else
                    check("good_cnt", good_cnt, 0);
                    check("bad_cnt", bad_cnt, 0);
`endif
                end
            end
        end
    end

    initial begin
        bq_t f, g;
        int  plen;
        reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_data = 8'h00;
        idle(3);
        check_all_zero("reset");
        reset = 1'b0;
        idle(2);

        // Stray bytes without a frame start are ignored
        @(negedge clk); in_valid = 1'b1; in_data = 8'hA5; in_eof = 1'b1;
        idle(2);

        f = build_good(60, 1'b1);
        send(f, 0);

        g = f;
        g[10] = g[10] ^ 8'h01;
        send(g, 0);

        f = '{8'h11, 8'h22, 8'h33};
        send(f, 0);

        f = '{8'h5A};
        send(f, 0);
        f = build_good(0, 1'b0);
        send(f, 0);
        f = build_good(1, 1'b0);
        send(f, 0);

        // Abort at byte 20, then a good frame
        f = build_good(80, 1'b0);
        expect_frame(f, 20);
        drive(f, 20, 0);
        expect_abort();
        g = build_good(60, 1'b0);
        send(g, 0);

        f = build_good(60, 1'b1);
        send(f, 1);

        // Length boundaries
        send(build_good(59, 1'b0), 0);
        send(build_good(60, 1'b0), 2);
        send(build_good(1514, 1'b0), 0);
        send(build_good(1515, 1'b0), 0);

        // Reset mid-frame at byte 30
        f = build_good(70, 1'b0);
        expect_frame(f, 30);
        drive(f, 30, 0);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        #1;
        check_all_zero("async_reset");
        good_m = 0;
        bad_m  = 0;
        idle(2);
        reset = 1'b0;
        idle(1);
        send(build_good(60, 1'b1), 0);
        idle(2);
`ifdef CRC32_RX_CHECK_STATS_EN
        check("post_reset_good_cnt", good_cnt, 1);
`else
        check("post_reset_good_cnt", good_cnt, 0);
`endif

        // Randomized frames with random gaps and occasional corruption
        for (int r = 0; r < 24; r++) begin
            plen = $urandom_range(100, 0);
            f = build_good(plen, 1'b0);
            if ($urandom_range(3, 0) == 0) begin
                int idx;
                idx = $urandom_range(f.size() - 1, 0);
                f[idx] = f[idx] ^ 8'(1 << $urandom_range(7, 0));
            end
            send(f, 2);
        end

        idle(20);
        check("exp_bytes_left", exp_b.size(), 0);
        check("exp_status_left", exp_s.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
